// File: rtl/eth_wb_master_arbiter.sv
// Arbitrates the Ethernet DMA Wishbone master port between Tx reads and Rx writes, using round-robin selection and single or fixed-length bursts.
// Latency: the grant is combinational in IDLE/DONE. cyc/stb rise one cycle after the grant. Acks and errors reach the owner in the same cycle.
// Backpressure: the slave stalls by withholding ack. A watchdog aborts the transfer after TIMEOUT unacknowledged strobe cycles.
module eth_wb_master_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        WB_CLK_I,
    input  logic        Reset_n,
    input  logic        tx_req,
    input  logic [29:0] tx_adr,
    input  logic        tx_burst,
    output logic        tx_gnt,
    output logic        tx_ack,
    output logic [31:0] tx_dat,
    output logic        tx_err,
    input  logic        rx_req,
    input  logic [29:0] rx_adr,
    input  logic        rx_burst,
    input  logic [31:0] rx_dat,
    input  logic [3:0]  rx_sel,
    output logic        rx_gnt,
    output logic        rx_ack,
    output logic        rx_err,
    output logic [29:0] m_wb_adr_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_we_o,
    output logic [31:0] m_wb_dat_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic [2:0]  m_wb_cti_o,
    output logic [1:0]  m_wb_bte_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,
    input  logic        m_wb_err_i,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    // The beat counter holds the number of beats still to be acked.
    localparam logic [4:0] BEATS_BURST = 5'(BURST_LEN);
    // The watchdog fires during the TIMEOUT-th strobe cycle without ack/err.
    localparam logic [9:0] WD_LIMIT    = 10'(TIMEOUT - 1);

    state_t      state;
    logic        owner_rx;
    logic        last_rx;
    logic        burst_q;
    logic [4:0]  beats;
    logic [9:0]  wd_cnt;

    logic        can_grant;
    logic        grant_tx;
    logic        grant_rx;
    logic        timeout;
    logic        bus_err;
    logic        bus_ack;
    logic        last_beat;

    // DONE counts as an arbitration point so only one cyc-low cycle separates transfers.
    assign can_grant = (state == IDLE) || (state == DONE);
    assign grant_tx  = can_grant && tx_req && (!rx_req || last_rx);
    assign grant_rx  = can_grant && rx_req && (!tx_req || !last_rx);

    // Err (real or watchdog) takes priority over ack in the same cycle.
    assign timeout   = (wd_cnt >= WD_LIMIT);
    assign bus_err   = m_wb_stb_o && (m_wb_err_i || timeout);
    assign bus_ack   = m_wb_stb_o && m_wb_ack_i && !bus_err;
    assign last_beat = (beats == 5'd1);

    assign tx_gnt     = grant_tx;
    assign rx_gnt     = grant_rx;
    assign tx_ack     = bus_ack && !owner_rx;
    assign rx_ack     = bus_ack && owner_rx;
    assign tx_err     = bus_err && !owner_rx;
    assign rx_err     = bus_err && owner_rx;
    assign tx_dat     = m_wb_dat_i;
    assign m_wb_dat_o = (m_wb_stb_o && owner_rx) ? rx_dat : 32'h0;
    assign m_wb_bte_o = 2'b00;
    assign busy       = grant_tx || grant_rx || (state != IDLE);

    // The cycle type comes from the latched burst flag and the remaining beat count.
    always_comb begin
        m_wb_cti_o = 3'b000;
        if (m_wb_stb_o && burst_q) begin
            m_wb_cti_o = last_beat ? 3'b111 : 3'b010;
        end
    end

    // Main FSM: grant and latch the request, run the beats, then hold one turnaround cycle.
    always_ff @(posedge WB_CLK_I or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            owner_rx   <= 1'b0;
            last_rx    <= 1'b1;
            burst_q    <= 1'b0;
            beats      <= 5'd0;
            wd_cnt     <= 10'd0;
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            m_wb_we_o  <= 1'b0;
            m_wb_adr_o <= 30'h0;
            m_wb_sel_o <= 4'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (grant_tx || grant_rx) begin
                        state      <= XFER;
                        m_wb_cyc_o <= 1'b1;
                        m_wb_stb_o <= 1'b1;
                        owner_rx   <= grant_rx;
                        last_rx    <= grant_rx;
                        m_wb_we_o  <= grant_rx;
                        m_wb_adr_o <= grant_rx ? rx_adr : tx_adr;
                        m_wb_sel_o <= grant_rx ? rx_sel : 4'hF;
                        burst_q    <= grant_rx ? rx_burst : tx_burst;
                        beats      <= (grant_rx ? rx_burst : tx_burst) ? BEATS_BURST : 5'd1;
                        wd_cnt     <= 10'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    if (bus_err) begin
                        // Abort: discard the remaining beats and keep the failing address.
                        m_wb_cyc_o <= 1'b0;
                        m_wb_stb_o <= 1'b0;
                        m_wb_we_o  <= 1'b0;
                        wd_cnt     <= 10'd0;
                        state      <= DONE;
                    end else if (bus_ack) begin
                        m_wb_adr_o <= m_wb_adr_o + 30'd1;
                        beats      <= beats - 5'd1;
                        wd_cnt     <= 10'd0;
                        if (last_beat) begin
                            m_wb_cyc_o <= 1'b0;
                            m_wb_stb_o <= 1'b0;
                            m_wb_we_o  <= 1'b0;
                            state      <= DONE;
                        end
                    end else if (wd_cnt != 10'h3FF) begin
                        wd_cnt <= wd_cnt + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_wb_master_arbiter.sv
// Directed bench for eth_wb_master_arbiter using BURST_LEN=4 and TIMEOUT=255.
// Inputs change 1ns after the rising edge. Outputs are sampled 3ns after the rising edge.
// Each scenario task performs its own comparisons and updates the shared counters.
module tb_eth_wb_master_arbiter;

    logic        WB_CLK_I;
    logic        Reset_n;
    logic        tx_req, tx_burst, tx_gnt, tx_ack, tx_err;
    logic [29:0] tx_adr;
    logic [31:0] tx_dat;
    logic        rx_req, rx_burst, rx_gnt, rx_ack, rx_err;
    logic [29:0] rx_adr;
    logic [31:0] rx_dat;
    logic [3:0]  rx_sel;
    logic [29:0] m_wb_adr_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
    logic [31:0] m_wb_dat_o, m_wb_dat_i;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic        m_wb_ack_i, m_wb_err_i, busy;

    int tests  = 0;
    int failed = 0;

    eth_wb_master_arbiter #(.BURST_LEN(4), .TIMEOUT(255)) dut (
        .WB_CLK_I(WB_CLK_I), .Reset_n(Reset_n),
        .tx_req(tx_req), .tx_adr(tx_adr), .tx_burst(tx_burst), .tx_gnt(tx_gnt),
        .tx_ack(tx_ack), .tx_dat(tx_dat), .tx_err(tx_err),
        .rx_req(rx_req), .rx_adr(rx_adr), .rx_burst(rx_burst), .rx_dat(rx_dat),
        .rx_sel(rx_sel), .rx_gnt(rx_gnt), .rx_ack(rx_ack), .rx_err(rx_err),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o),
        .m_wb_dat_o(m_wb_dat_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
        .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o), .m_wb_dat_i(m_wb_dat_i),
        .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i), .busy(busy)
    );

    initial begin
        WB_CLK_I = 1'b0;
        forever #5 WB_CLK_I = ~WB_CLK_I;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500us, required completion");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge WB_CLK_I);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        tx_req = 0; tx_adr = '0; tx_burst = 0;
        rx_req = 0; rx_adr = '0; rx_burst = 0; rx_dat = '0; rx_sel = '0;
        m_wb_dat_i = '0; m_wb_ack_i = 0; m_wb_err_i = 0;
        #3;
        tests++;
        if ({m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, busy, tx_gnt, rx_gnt} !== 6'b0) begin
            failed++; $display("FAIL reset_ctrl: got %b want 000000",
                {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, busy, tx_gnt, rx_gnt});
        end
        tests++;
        if ({m_wb_adr_o, m_wb_sel_o, m_wb_dat_o, m_wb_cti_o, m_wb_bte_o} !== '0) begin
            failed++; $display("FAIL reset_bus: adr=%h sel=%h dat=%h cti=%b bte=%b want all 0",
                m_wb_adr_o, m_wb_sel_o, m_wb_dat_o, m_wb_cti_o, m_wb_bte_o);
        end
        repeat (2) @(posedge WB_CLK_I);
        #1 Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_tx_single();
        tx_req = 1; tx_adr = 30'h100; tx_burst = 0;
        #2;
        tests++;
        if (tx_gnt !== 1'b1 || rx_gnt !== 1'b0 || busy !== 1'b1 || m_wb_cyc_o !== 1'b0) begin
            failed++; $display("FAIL txs_grant: tx_gnt=%b rx_gnt=%b busy=%b cyc=%b want 1 0 1 0",
                tx_gnt, rx_gnt, busy, m_wb_cyc_o);
        end
        tick();
        tx_req = 0;
        m_wb_dat_i = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            m_wb_ack_i = (i == 2);
            #2;
            tests++;
            if (m_wb_cyc_o !== 1'b1 || m_wb_stb_o !== 1'b1 || m_wb_adr_o !== 30'h100 ||
                m_wb_cti_o !== 3'b000 || m_wb_we_o !== 1'b0 || tx_gnt !== 1'b0) begin
                failed++; $display("FAIL txs_bus[%0d]: cyc=%b stb=%b adr=%h cti=%b we=%b gnt=%b want 1 1 100 000 0 0",
                    i, m_wb_cyc_o, m_wb_stb_o, m_wb_adr_o, m_wb_cti_o, m_wb_we_o, tx_gnt);
            end
            tests++;
            if (tx_ack !== (i == 2) || (i == 2 && tx_dat !== 32'hDEADBEEF) || rx_ack !== 1'b0) begin
                failed++; $display("FAIL txs_ack[%0d]: tx_ack=%b tx_dat=%h rx_ack=%b want %b deadbeef 0",
                    i, tx_ack, tx_dat, rx_ack, (i == 2));
            end
            tick();
        end
        m_wb_ack_i = 0;
        #2;
        tests++;
        if (m_wb_cyc_o !== 1'b0 || busy !== 1'b1) begin
            failed++; $display("FAIL txs_done: cyc=%b busy=%b want 0 1", m_wb_cyc_o, busy);
        end
        tick();
        #2;
        tests++;
        if (busy !== 1'b0) begin
            failed++; $display("FAIL txs_idle: busy=%b want 0", busy);
        end
        tick();
    endtask

    task automatic test_rx_burst_wrap();
        logic [29:0] exp_adr [4];
        logic [2:0]  exp_cti [4];
        exp_adr[0] = 30'h3FFFFFFE; exp_adr[1] = 30'h3FFFFFFF; exp_adr[2] = 30'h0; exp_adr[3] = 30'h1;
        exp_cti[0] = 3'b010; exp_cti[1] = 3'b010; exp_cti[2] = 3'b010; exp_cti[3] = 3'b111;
        rx_req = 1; rx_adr = 30'h3FFFFFFE; rx_burst = 1; rx_sel = 4'b0101;
        #2;
        tests++;
        if (rx_gnt !== 1'b1 || tx_gnt !== 1'b0) begin
            failed++; $display("FAIL rxb_grant: rx_gnt=%b tx_gnt=%b want 1 0", rx_gnt, tx_gnt);
        end
        tick();
        rx_req = 0;
        m_wb_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            rx_dat = 32'hA5A50000 + 32'(i);
            #2;
            tests++;
            if (m_wb_adr_o !== exp_adr[i] || m_wb_cti_o !== exp_cti[i] || m_wb_we_o !== 1'b1 ||
                m_wb_sel_o !== 4'b0101 || m_wb_bte_o !== 2'b00 || m_wb_stb_o !== 1'b1) begin
                failed++; $display("FAIL rxb_beat[%0d]: adr=%h cti=%b we=%b sel=%b bte=%b stb=%b want %h %b 1 0101 00 1",
                    i, m_wb_adr_o, m_wb_cti_o, m_wb_we_o, m_wb_sel_o, m_wb_bte_o, m_wb_stb_o,
                    exp_adr[i], exp_cti[i]);
            end
            tests++;
            if (rx_ack !== 1'b1 || tx_ack !== 1'b0 || m_wb_dat_o !== 32'hA5A50000 + 32'(i)) begin
                failed++; $display("FAIL rxb_ack[%0d]: rx_ack=%b tx_ack=%b dat_o=%h want 1 0 %h",
                    i, rx_ack, tx_ack, m_wb_dat_o, 32'hA5A50000 + 32'(i));
            end
            tick();
        end
        m_wb_ack_i = 0;
        #2;
        tests++;
        if (m_wb_cyc_o !== 1'b0 || m_wb_we_o !== 1'b0 || m_wb_dat_o !== 32'h0) begin
            failed++; $display("FAIL rxb_end: cyc=%b we=%b dat_o=%h want 0 0 0", m_wb_cyc_o, m_wb_we_o, m_wb_dat_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // Rx owned the previous transfer, so Tx wins first.
        tx_req = 1; tx_adr = 30'h10; tx_burst = 0;
        rx_req = 1; rx_adr = 30'h20; rx_burst = 0; rx_sel = 4'hF;
        m_wb_ack_i = 1;
        for (int c = 0; c < 8; c++) begin
            #2;
            tests++;
            if (tx_gnt !== (c % 4 == 0) || rx_gnt !== (c % 4 == 2) || m_wb_cyc_o !== (c % 2 == 1)) begin
                failed++; $display("FAIL b2b_cycle[%0d]: tx_gnt=%b rx_gnt=%b cyc=%b want %b %b %b",
                    c, tx_gnt, rx_gnt, m_wb_cyc_o, (c % 4 == 0), (c % 4 == 2), (c % 2 == 1));
            end
            tick();
        end
        tx_req = 0; rx_req = 0; m_wb_ack_i = 0;
        #2;
        tests++;
        if (m_wb_cyc_o !== 1'b0 || busy !== 1'b1 || tx_gnt !== 1'b0) begin
            failed++; $display("FAIL b2b_done: cyc=%b busy=%b tx_gnt=%b want 0 1 0", m_wb_cyc_o, busy, tx_gnt);
        end
        tick();
    endtask

    task automatic test_burst_err();
        int acks = 0;
        int stbs = 0;
        tx_req = 1; tx_adr = 30'h40; tx_burst = 1;
        #2;
        tests++;
        if (tx_gnt !== 1'b1) begin
            failed++; $display("FAIL err_grant: tx_gnt=%b want 1", tx_gnt);
        end
        tick();
        tx_req = 0;
        m_wb_ack_i = 1;
        #2;
        tests++;
        if (tx_ack !== 1'b1 || m_wb_adr_o !== 30'h40 || m_wb_cti_o !== 3'b010) begin
            failed++; $display("FAIL err_beat1: ack=%b adr=%h cti=%b want 1 040 010", tx_ack, m_wb_adr_o, m_wb_cti_o);
        end
        tick();
        m_wb_err_i = 1;
        #2;
        tests++;
        if (tx_err !== 1'b1 || tx_ack !== 1'b0 || rx_err !== 1'b0 || m_wb_adr_o !== 30'h41) begin
            failed++; $display("FAIL err_beat2: err=%b ack=%b rx_err=%b adr=%h want 1 0 0 041",
                tx_err, tx_ack, rx_err, m_wb_adr_o);
        end
        tick();
        m_wb_err_i = 0; m_wb_ack_i = 0;
        #2;
        tests++;
        if (m_wb_cyc_o !== 1'b0 || m_wb_stb_o !== 1'b0 || m_wb_adr_o !== 30'h41 || tx_err !== 1'b0) begin
            failed++; $display("FAIL err_drop: cyc=%b stb=%b adr=%h err=%b want 0 0 041 0",
                m_wb_cyc_o, m_wb_stb_o, m_wb_adr_o, tx_err);
        end
        m_wb_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #2;
            if (m_wb_stb_o) stbs++;
            if (tx_ack) acks++;
        end
        m_wb_ack_i = 0;
        tests++;
        if (stbs != 0 || acks != 0) begin
            failed++; $display("FAIL err_no_more_beats: stb_cycles=%0d acks=%0d want 0 0", stbs, acks);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        bit found = 0;
        rx_req = 1; rx_adr = 30'h200; rx_burst = 0; rx_sel = 4'hF;
        #2;
        tests++;
        if (rx_gnt !== 1'b1) begin
            failed++; $display("FAIL wd_grant: rx_gnt=%b want 1", rx_gnt);
        end
        tick();
        rx_req = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            #2;
            if (m_wb_stb_o) n++;
            if (rx_err) found = 1;
            tick();
        end
        tests++;
        if (!found || n != 255) begin
            failed++; $display("FAIL wd_count: err_seen=%0d stb_cycles=%0d want 1 255", found, n);
        end
        #2;
        tests++;
        if (m_wb_cyc_o !== 1'b0 || rx_err !== 1'b0) begin
            failed++; $display("FAIL wd_drop: cyc=%b rx_err=%b want 0 0", m_wb_cyc_o, rx_err);
        end
        tick();
        tx_req = 1; tx_adr = 30'h300; tx_burst = 0;
        #2;
        tests++;
        if (tx_gnt !== 1'b1) begin
            failed++; $display("FAIL wd_next_grant: tx_gnt=%b want 1", tx_gnt);
        end
        tick();
        tx_req = 0;
        m_wb_ack_i = 1;
        #2;
        tests++;
        if (tx_ack !== 1'b1 || m_wb_adr_o !== 30'h300) begin
            failed++; $display("FAIL wd_next_ack: ack=%b adr=%h want 1 300", tx_ack, m_wb_adr_o);
        end
        tick();
        m_wb_ack_i = 0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        rx_req = 1; rx_adr = 30'h500; rx_burst = 1; rx_sel = 4'h3; rx_dat = 32'h12345678;
        #2;
        tests++;
        if (rx_gnt !== 1'b1) begin
            failed++; $display("FAIL rst_grant: rx_gnt=%b want 1", rx_gnt);
        end
        tick();
        rx_req = 0;
        m_wb_ack_i = 1;
        tick();
        tick();
        m_wb_ack_i = 0;
        #2;
        tests++;
        if (m_wb_stb_o !== 1'b1 || m_wb_adr_o !== 30'h502 || m_wb_we_o !== 1'b1 || m_wb_cti_o !== 3'b010) begin
            failed++; $display("FAIL rst_beat3: stb=%b adr=%h we=%b cti=%b want 1 502 1 010",
                m_wb_stb_o, m_wb_adr_o, m_wb_we_o, m_wb_cti_o);
        end
        Reset_n = 0;
        #1;
        tests++;
        if ({m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_cti_o, rx_err, tx_err, busy} !== 9'b0) begin
            failed++; $display("FAIL rst_async: cyc=%b stb=%b we=%b cti=%b rx_err=%b tx_err=%b busy=%b want all 0",
                m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_cti_o, rx_err, tx_err, busy);
        end
        tick();
        tick();
        Reset_n = 1;
        tx_req = 1; tx_adr = 30'h600; tx_burst = 0;
        rx_req = 1; rx_adr = 30'h700; rx_burst = 0;
        #2;
        tests++;
        if (tx_gnt !== 1'b1 || rx_gnt !== 1'b0) begin
            failed++; $display("FAIL rst_first_owner: tx_gnt=%b rx_gnt=%b want 1 0", tx_gnt, rx_gnt);
        end
        tick();
        tx_req = 0; rx_req = 0;
        m_wb_ack_i = 1;
        tick();
        m_wb_ack_i = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_rx_burst_wrap();
        test_back_to_back();
        test_burst_err();
        test_timeout();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
